// File: rtl/audio_event_seq_pkg.sv
// Shared constants and state encoding for the game audio event sequencer.
package audio_pkg;

   localparam int CLK_HZ          = 100_000_000;
   localparam int TICK_1S         = CLK_HZ;
   localparam int GOAL_HOLD_DEF   = 150_000_000;
   localparam int COUNT_BEEPS_DEF = 3;

   typedef enum logic [1:0] {
      E_IDLE      = 2'd0,
      E_COUNT     = 2'd1,
      E_GOAL_HOLD = 2'd2
   } state_e;

   // Plain-vector aliases so the state register stays an ordinary logic vector
   localparam logic [1:0] IDLE      = E_IDLE;
   localparam logic [1:0] COUNT     = E_COUNT;
   localparam logic [1:0] GOAL_HOLD = E_GOAL_HOLD;

endpackage

// File: rtl/audio_event_seq_if.sv
// Game-state inputs and play-pulse outputs of the audio event sequencer.
interface audio_event_seq_if
   import audio_pkg::*;
#(
   parameter int BL_W = $clog2(COUNT_BEEPS_DEF + 1)
) ();

   logic            game_begin;
   logic            score_a;
   logic            score_b;
   logic            abort;
   logic            goal;
   logic            cnt;
   logic            start;
   logic            busy;
   logic [BL_W-1:0] beeps_left;

   modport master (
      output game_begin, score_a, score_b, abort,
      input  goal, cnt, start, busy, beeps_left
   );

   modport slave (
      input  game_begin, score_a, score_b, abort,
      output goal, cnt, start, busy, beeps_left
   );

endinterface

// File: rtl/audio_event_seq_edge.sv
// Registered rising-edge detector; history resets high so a level already
// asserted when reset releases is not mistaken for a new event.
module rise_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (rst) r_prev <= 1'b1;
      else     r_prev <= i_d;
   end

   assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/audio_event_seq.sv
// Turns game-state levels into one-cycle goal/cnt/start play pulses, runs the
// pre-match countdown and rate-limits goal clips with a one-deep pending slot.
module audio_event_seq
   import audio_pkg::*;
#(
   parameter int TICK_CYCLES      = TICK_1S,
   parameter int COUNT_BEEPS      = COUNT_BEEPS_DEF,
   parameter int GOAL_HOLD_CYCLES = GOAL_HOLD_DEF
) (
   input logic             clk,
   input logic             rst,
   audio_event_seq_if.slave bus
);

   localparam int BL_W = $clog2(COUNT_BEEPS + 1);
   localparam int TK_W = $clog2(TICK_CYCLES);
   localparam int HD_W = $clog2(GOAL_HOLD_CYCLES);

   localparam logic [TK_W-1:0] TICK_LAST  = TK_W'(TICK_CYCLES - 1);
   localparam logic [HD_W-1:0] HOLD_LAST  = HD_W'(GOAL_HOLD_CYCLES - 1);
   localparam logic [BL_W-1:0] BEEPS_INIT = BL_W'(COUNT_BEEPS - 1);

   logic [2:0] w_raw;
   logic [2:0] w_rise;
   logic       w_begin_edge;
   logic       w_score_edge;

   assign w_raw = {bus.score_b, bus.score_a, bus.game_begin};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_edge
         rise_edge_det u_det (
            .clk    (clk),
            .rst    (rst),
            .i_d    (w_raw[gi]),
            .o_rise (w_rise[gi])
         );
      end
   endgenerate

   assign w_begin_edge = w_rise[0];
   assign w_score_edge = w_rise[1] | w_rise[2];

   logic [1:0]      r_state,   w_state_next;
   logic            r_pending, w_pending_next;
   logic [BL_W-1:0] r_beeps,   w_beeps_next;
   logic [TK_W-1:0] r_tick,    w_tick_next;
   logic [HD_W-1:0] r_hold,    w_hold_next;
   logic            r_goal,    w_goal_next;
   logic            r_cnt,     w_cnt_next;
   logic            r_start,   w_start_next;
   logic            r_busy,    w_busy_next;

   always_comb begin
      w_state_next   = r_state;
      w_pending_next = r_pending;
      w_beeps_next   = r_beeps;
      w_tick_next    = r_tick;
      w_hold_next    = r_hold;
      w_goal_next    = 1'b0;
      w_cnt_next     = 1'b0;
      w_start_next   = 1'b0;

      if (bus.abort) begin
         w_state_next   = IDLE;
         w_pending_next = 1'b0;
         w_beeps_next   = '0;
         w_tick_next    = '0;
         w_hold_next    = '0;
      end else if (w_begin_edge) begin
         // A new countdown pre-empts everything, including a queued goal
         w_state_next   = COUNT;
         w_cnt_next     = 1'b1;
         w_beeps_next   = BEEPS_INIT;
         w_tick_next    = '0;
         w_hold_next    = '0;
         w_pending_next = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_score_edge) begin
                  w_state_next = GOAL_HOLD;
                  w_goal_next  = 1'b1;
                  w_hold_next  = '0;
               end
            end
            COUNT: begin
               if (r_tick == TICK_LAST) begin
                  w_tick_next = '0;
                  if (r_beeps != '0) begin
                     w_cnt_next   = 1'b1;
                     w_beeps_next = r_beeps - BL_W'(1);
                  end else begin
                     w_start_next = 1'b1;
                     w_state_next = IDLE;
                  end
               end else begin
                  w_tick_next = r_tick + TK_W'(1);
               end
            end
            GOAL_HOLD: begin
               if (r_hold == HOLD_LAST) begin
                  // A score arriving in the expiry cycle itself still queues
                  if (r_pending | w_score_edge) begin
                     w_goal_next = 1'b1;
                     w_hold_next = '0;
                  end else begin
                     w_state_next = IDLE;
                  end
                  w_pending_next = 1'b0;
               end else begin
                  w_hold_next = r_hold + HD_W'(1);
                  if (w_score_edge) w_pending_next = 1'b1;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end

      // busy also covers the start-pulse cycle so the countdown reads as one span
      w_busy_next = (w_state_next != IDLE) | w_start_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pending <= 1'b0;
         r_beeps   <= '0;
         r_tick    <= '0;
         r_hold    <= '0;
         r_goal    <= 1'b0;
         r_cnt     <= 1'b0;
         r_start   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_pending <= w_pending_next;
         r_beeps   <= w_beeps_next;
         r_tick    <= w_tick_next;
         r_hold    <= w_hold_next;
         r_goal    <= w_goal_next;
         r_cnt     <= w_cnt_next;
         r_start   <= w_start_next;
         r_busy    <= w_busy_next;
      end
   end

   assign bus.goal       = r_goal;
   assign bus.cnt        = r_cnt;
   assign bus.start      = r_start;
   assign bus.busy       = r_busy;
   assign bus.beeps_left = r_beeps;

endmodule

// File: tb/tb_audio_event_seq.sv
// Directed table-driven and randomized checks for audio_event_seq with short
// timing (tick 10, 3 beeps, hold 20).
module tb_audio_event_seq;

   localparam int TICK = 10;
   localparam int NB   = 3;
   localparam int HOLD = 20;
   localparam int BL_W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   audio_event_seq_if #(.BL_W(BL_W)) bus_if ();

   audio_event_seq #(
      .TICK_CYCLES      (TICK),
      .COUNT_BEEPS      (NB),
      .GOAL_HOLD_CYCLES (HOLD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // in  = {game_begin, score_a, score_b, abort}
   // ex  = {goal, cnt, start, busy, beeps_left[1:0]}
   typedef struct {
      string      seg;
      int         cyc;
      logic [3:0] in;
      logic [5:0] ex;
   } vec_t;

   vec_t vt[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic void add(input string s, input int c, input logic [3:0] in, input logic [5:0] ex);
      vec_t v;
      v.seg = s;
      v.cyc = c;
      v.in  = in;
      v.ex  = ex;
      vt.push_back(v);
   endfunction

   function automatic logic [5:0] outs();
      return {bus_if.goal, bus_if.cnt, bus_if.start, bus_if.busy, bus_if.beeps_left};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] in);
      {bus_if.game_begin, bus_if.score_a, bus_if.score_b, bus_if.abort} = in;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic gb);
      rst = 1'b1;
      drive({gb, 3'b000});
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'(outs()), 32'd0);
      rst = 1'b0;
   endtask

   // Cycle n is the period after the n-th posedge following reset release.
   // Inputs listed for cycle n are evaluated at the edge ending cycle n.
   task automatic run_seg(input string name, input int ncyc);
      logic [3:0] cur_in;
      logic [2:0] cur_lvl;
      logic [2:0] cur_pls;
      cur_in  = 4'b0000;
      cur_lvl = 3'b000;
      for (int n = 0; n < ncyc; n++) begin
         tick();
         cur_pls = 3'b000;
         for (int k = 0; k < vt.size(); k++) begin
            if (vt[k].seg == name && vt[k].cyc == n) begin
               cur_in  = vt[k].in;
               cur_lvl = vt[k].ex[2:0];
               cur_pls = vt[k].ex[5:3];
               $display("[TB] %s cyc %0d in=%b exp=%b got=%b", name, n, vt[k].in, vt[k].ex, outs());
            end
         end
         check($sformatf("%s_cyc%0d", name, n), 32'(outs()), 32'({cur_pls, cur_lvl}));
         drive(cur_in);
      end
   endtask

   initial begin
      int last_goal;
      int pulses;

      // Countdown: begin edge at 5 -> cnt 6,16,26, start 36, busy low at 37
      add("cd",  0, 4'b0000, 6'b000000);
      add("cd",  5, 4'b1000, 6'b000000);
      add("cd",  6, 4'b1000, 6'b010110);
      add("cd", 16, 4'b0000, 6'b010101);
      add("cd", 26, 4'b0000, 6'b010100);
      add("cd", 36, 4'b0000, 6'b001100);
      add("cd", 37, 4'b0000, 6'b000000);

      // Back-to-back goals: A at 50, B at 55 queued, A at 60 dropped
      add("gl",  0, 4'b0000, 6'b000000);
      add("gl", 50, 4'b0100, 6'b000000);
      add("gl", 51, 4'b0100, 6'b100100);
      add("gl", 53, 4'b0000, 6'b000100);
      add("gl", 55, 4'b0010, 6'b000100);
      add("gl", 60, 4'b0110, 6'b000100);
      add("gl", 71, 4'b0110, 6'b100100);
      add("gl", 91, 4'b0110, 6'b000000);

      // Simultaneous begin + score: countdown wins, later score ignored
      add("sm",  0, 4'b0000, 6'b000000);
      add("sm", 10, 4'b1100, 6'b000000);
      add("sm", 11, 4'b1100, 6'b010110);
      add("sm", 15, 4'b1110, 6'b000110);
      add("sm", 21, 4'b1110, 6'b010101);
      add("sm", 31, 4'b1110, 6'b010100);
      add("sm", 41, 4'b1110, 6'b001100);
      add("sm", 42, 4'b1110, 6'b000000);

      // Abort mid-countdown suppresses cnt at 21; score edge during abort lost
      add("ab",  0, 4'b0000, 6'b000000);
      add("ab", 10, 4'b1000, 6'b000000);
      add("ab", 11, 4'b1000, 6'b010110);
      add("ab", 20, 4'b1001, 6'b000110);
      add("ab", 21, 4'b1001, 6'b000000);
      add("ab", 22, 4'b1101, 6'b000000);
      add("ab", 23, 4'b1100, 6'b000000);

      do_reset(1'b0);
      run_seg("cd", 45);
      do_reset(1'b0);
      run_seg("gl", 100);
      do_reset(1'b0);
      run_seg("sm", 50);
      do_reset(1'b0);
      run_seg("ab", 60);

      // game_begin held high through reset release must not start a countdown
      do_reset(1'b1);
      pulses = 0;
      for (int n = 0; n < 30; n++) begin
         tick();
         if (outs() != 6'd0) pulses++;
      end
      check("begin_high_at_reset", 32'(pulses), 32'd0);
      $display("[TB] begin-high-through-reset: %0d active cycles", pulses);

      // Reset in the middle of a goal hold with a goal pending
      do_reset(1'b0);
      tick();
      drive(4'b0100);
      tick();
      check("hold_goal_first", 32'(outs()), 32'(6'b100100));
      drive(4'b0110);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("hold_reset_outputs", 32'(outs()), 32'd0);
      rst = 1'b0;
      pulses = 0;
      for (int n = 0; n < 50; n++) begin
         tick();
         if (bus_if.goal || bus_if.busy) pulses++;
      end
      check("hold_reset_no_later_goal", 32'(pulses), 32'd0);
      $display("[TB] reset-mid-hold: %0d active cycles after reset", pulses);

      // Random stimulus: one-hot pulses and minimum goal spacing
      do_reset(1'b0);
      last_goal = -1000;
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(0, 99) < 2) bus_if.game_begin = ~bus_if.game_begin;
         if ($urandom_range(0, 99) < 8) bus_if.score_a    = ~bus_if.score_a;
         if ($urandom_range(0, 99) < 8) bus_if.score_b    = ~bus_if.score_b;
         bus_if.abort = ($urandom_range(0, 299) == 0);
         if (bus_if.abort) last_goal = -1000;
         tick();
         check($sformatf("onehot_cyc%0d", n),
               32'($countones({bus_if.goal, bus_if.cnt, bus_if.start}) <= 1), 32'd1);
         if (bus_if.goal) begin
            check($sformatf("goal_gap_cyc%0d", n), 32'((n - last_goal) >= HOLD), 32'd1);
            last_goal = n;
         end
      end
      $display("[TB] random run of 10000 cycles complete");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/audio_event_seq.md
Name: audio_event_seq

Overview:
- Upstream event sequencer for the game audio stage. Converts raw game-state signals into single-cycle play pulses (goal, cnt, start) that feed the audio output stage.
- Runs the pre-match countdown: N count beeps at a fixed interval, then one start beep.
- Rate-limits goal sounds so a second goal never retriggers a clip that is still playing. At most one goal is queued while a clip plays.

Parameters:
- TICK_CYCLES, 100_000_000, cycles between successive countdown beeps (1 s at 100 MHz); minimum 2.
- COUNT_BEEPS, 3, number of cnt pulses before the start pulse; minimum 1.
- GOAL_HOLD_CYCLES, 150_000_000, lockout after a goal pulse (covers clip length); minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- game_begin  in  1  level; its rising edge requests a countdown.
- score_a  in  1  level; rising edge = player A scored.
- score_b  in  1  level; rising edge = player B scored.
- abort  in  1  level; while high, forces IDLE and suppresses all pulses.
- goal  out  1  one-cycle play pulse for the goal clip.
- cnt  out  1  one-cycle play pulse for the count beep.
- start  out  1  one-cycle play pulse for the start clip.
- busy  out  1  high in any state other than IDLE.
- beeps_left  out  $clog2(COUNT_BEEPS+1)  cnt pulses still to be issued in the current countdown.

Behaviour:
- Reset (synchronous, active-high; rst has priority over all inputs):
  - goal, cnt, start, busy, beeps_left all 0.
  - State = IDLE, pending = 0, counters = 0.
  - Edge-detect history registers reset to 1, so an input already high when reset releases does not trigger.
- Edge detection:
  - Each of game_begin, score_a, score_b is registered once: prev <= input.
  - edge = input & ~prev, evaluated in cycle D.
  - score_edge = edge(score_a) | edge(score_b). Simultaneous A and B edges count as one goal.
- FSM states: IDLE, COUNT, GOAL_HOLD.
- IDLE:
  - begin_edge at cycle D: cnt = 1 at D+1, beeps_left = COUNT_BEEPS-1 at D+1, go to COUNT, tick counter cleared.
  - Otherwise, score_edge at D: goal = 1 at D+1, go to GOAL_HOLD, hold counter cleared.
  - begin_edge wins over score_edge in the same cycle; the score edge is dropped.
- COUNT:
  - Tick counter counts to TICK_CYCLES-1 and wraps.
  - On each wrap with beeps_left > 0: cnt pulse and beeps_left decrements.
  - On the wrap with beeps_left == 0: start pulse and return to IDLE.
  - Resulting schedule: cnt at D+1+k*TICK_CYCLES for k = 0..COUNT_BEEPS-1; start at D+1+COUNT_BEEPS*TICK_CYCLES.
  - score_edge is ignored (no play in progress).
  - begin_edge restarts the countdown exactly as from IDLE.
- GOAL_HOLD:
  - Hold counter runs for GOAL_HOLD_CYCLES cycles after the goal pulse.
  - score_edge sets pending (saturates at 1; extra edges dropped).
  - At expiry:
    - If pending: clear pending, goal pulse in the expiry cycle +1, hold counter restarts, stay in GOAL_HOLD.
    - Otherwise: return to IDLE.
  - Gap between back-to-back goal pulses = exactly GOAL_HOLD_CYCLES.
  - begin_edge clears pending and starts the countdown (same timing as from IDLE).
- abort:
  - Highest priority after rst.
  - In any cycle with abort = 1: next state = IDLE, pending = 0, beeps_left = 0, and no pulse is asserted in the following cycle.
  - Edge history keeps tracking during abort, so edges that occur during abort are lost.
- Output rules:
  - At most one of goal/cnt/start is high in any cycle.
  - All outputs are registered (no combinational path from any input).
  - busy is registered, consistent with the state.

Decomposition:
- Shared package audio_pkg:
  - State enum {IDLE, COUNT, GOAL_HOLD}.
  - Default timing constants CLK_HZ, TICK_1S.
- One natural sub-module: rise_edge_det, a 1-bit registered edge detector with reset value 1. Instantiated three times.
- Counters and FSM stay in the top module.

Test Plan (TICK_CYCLES=10, COUNT_BEEPS=3, GOAL_HOLD_CYCLES=20):
- Countdown: game_begin 0->1 detected at cycle 5 -> cnt at 6, 16, 26; start at 36; beeps_left 2, 1, 0; busy 6..36, low at 37.
- Back-to-back goals: score_a edge at 50, score_b edge at 55 -> goal at 51 and 71; score_a edge at 60 dropped (pending already set); IDLE at 91.
- Simultaneous events: score_a and game_begin edges at cycle 10 in IDLE -> cnt at 11, no goal pulse; score edge during COUNT -> no goal.
- Abort: abort high at cycle 20 mid-countdown -> no cnt at 21; busy = 0 at 21; beeps_left = 0; no start pulse afterwards.
- Reset: game_begin held high through rst release -> no pulses; rst asserted mid-GOAL_HOLD -> all outputs 0 the next cycle, pending cleared, no later goal.
- Mutual exclusion: random score_a/score_b/game_begin/abort stimulus for 10k cycles -> goal+cnt+start ≤ 1 every cycle; goal pulses ≥ 20 cycles apart.
